// File: rtl/dpram_port_master.sv
// dpram_port_master: initiator for one port of the dual-port byte-enabled RAM.
// Turns byte-addressed byte/half/word requests and word read bursts into RAM
// word accesses. Read data is right-justified and returned through a
// credit-limited response FIFO.
module dpram_port_master #(
    parameter int ADDR_W    = 12,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [3:0]        req_len,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       ram_addr,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_last
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state_q;
    logic [WA_W-1:0] burstWa_q;
    logic [3:0]      beatsLeft_q;

    // Stage 1: RAM is sampling this beat's address. Stage 2: ram_dout is valid.
    logic            s1Valid_q, s1Signed_q, s1Last_q;
    logic [1:0]      s1Lane_q, s1Size_q;
    logic            s2Valid_q, s2Signed_q, s2Last_q;
    logic [1:0]      s2Lane_q, s2Size_q;

    logic [32:0]      fifoMem_q [RSP_DEPTH];
    logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
    logic [CNT_W-1:0] fifoCount_q;

    logic [1:0]      inflight;
    logic            creditOk;
    logic            reqReady;
    logic            accept;
    logic            isWord;
    logic [WA_W-1:0] reqWa;
    logic [3:0]      wrBe;
    logic [31:0]     wrDin;
    logic [31:0]     fmtData;
    logic [31:0]     byteShift;
    logic [31:0]     halfShift;
    logic            push;
    logic            pop;

    assign inflight = {1'b0, s1Valid_q} + {1'b0, s2Valid_q};
    assign creditOk = ({{(32-CNT_W){1'b0}}, fifoCount_q} + {30'b0, inflight}) < 32'(RSP_DEPTH);
    assign reqReady = !rst && (state_q == IDLE) && (req_we || creditOk);
    assign accept   = req_valid && reqReady;
    assign isWord   = req_size[1];
    assign reqWa    = req_addr[ADDR_W-1:2];

    assign req_ready = reqReady;
    assign push      = s2Valid_q;
    assign rsp_valid = (fifoCount_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? fifoMem_q[rdPtr_q][31:0] : 32'h0;
    assign rsp_last  = rsp_valid ? fifoMem_q[rdPtr_q][32] : 1'b0;

    // Write lane steering: replicate the data and enable only the addressed lanes.
    always_comb begin
        wrBe  = 4'h0;
        wrDin = req_wdata;
        case (req_size)
            2'd0: begin
                wrBe  = 4'b0001 << req_addr[1:0];
                wrDin = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                wrBe  = req_addr[1] ? 4'b1100 : 4'b0011;
                wrDin = {2{req_wdata[15:0]}};
            end
            default: begin
                wrBe  = 4'hF;
                wrDin = req_wdata;
            end
        endcase
    end

    // Read lane select and extension, using the size/lane carried with the beat.
    always_comb begin
        byteShift = ram_dout >> {s2Lane_q, 3'b000};
        halfShift = ram_dout >> {s2Lane_q[1], 4'b0000};
        case (s2Size_q)
            2'd0:    fmtData = s2Signed_q ? {{24{byteShift[7]}}, byteShift[7:0]}
                                          : {24'h0, byteShift[7:0]};
            2'd1:    fmtData = s2Signed_q ? {{16{halfShift[15]}}, halfShift[15:0]}
                                          : {16'h0, halfShift[15:0]};
            default: fmtData = ram_dout;
        endcase
    end

    // Request FSM: issues RAM accesses with registered RAM-side outputs.
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q     <= IDLE;
            burstWa_q   <= '0;
            beatsLeft_q <= '0;
            ram_addr    <= 32'h0;
            ram_we      <= 1'b0;
            ram_be      <= 4'h0;
            ram_din     <= 32'h0;
            s1Valid_q   <= 1'b0;
            s1Signed_q  <= 1'b0;
            s1Last_q    <= 1'b0;
            s1Lane_q    <= 2'd0;
            s1Size_q    <= 2'd0;
            s2Valid_q   <= 1'b0;
            s2Signed_q  <= 1'b0;
            s2Last_q    <= 1'b0;
            s2Lane_q    <= 2'd0;
            s2Size_q    <= 2'd0;
        end else begin
            ram_we     <= 1'b0;
            ram_be     <= 4'h0;
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= s1Valid_q;
            s2Signed_q <= s1Signed_q;
            s2Last_q   <= s1Last_q;
            s2Lane_q   <= s1Lane_q;
            s2Size_q   <= s1Size_q;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ram_addr <= 32'(reqWa);
                        if (req_we) begin
                            ram_we  <= 1'b1;
                            ram_be  <= wrBe;
                            ram_din <= wrDin;
                        end else begin
                            s1Valid_q  <= 1'b1;
                            s1Lane_q   <= req_addr[1:0];
                            s1Size_q   <= req_size;
                            s1Signed_q <= req_signed;
                            s1Last_q   <= !(isWord && (req_len != 4'd0));
                            if (isWord && (req_len != 4'd0)) begin
                                state_q     <= BURST;
                                burstWa_q   <= reqWa + WA_W'(1);
                                beatsLeft_q <= req_len;
                            end
                        end
                    end
                end
                BURST: begin
                    if (creditOk) begin
                        ram_addr    <= 32'(burstWa_q);
                        s1Valid_q   <= 1'b1;
                        s1Lane_q    <= 2'd0;
                        s1Size_q    <= 2'd2;
                        s1Signed_q  <= 1'b0;
                        s1Last_q    <= (beatsLeft_q == 4'd1);
                        burstWa_q   <= burstWa_q + WA_W'(1);
                        beatsLeft_q <= beatsLeft_q - 4'd1;
                        if (beatsLeft_q == 4'd1) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response FIFO pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge clka) begin
        if (rst) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= (wrPtr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= (rdPtr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fifoCount_q <= fifoCount_q + CNT_W'(1);
            end else if (pop && !push) begin
                fifoCount_q <= fifoCount_q - CNT_W'(1);
            end
        end
    end

    // Response FIFO storage: formatted read data plus its last-beat flag.
    always_ff @(posedge clka) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {s2Last_q, fmtData};
        end
    end

endmodule
